// File: rtl/adc16_sweep_pkg.sv
// ---------------------------------------------------------------------------
// adc16_sweep_pkg
// Shared types and constants for the ADC16 tap-sweep sequencer.
//   sweep_state_t : sequencer state encoding
//   result_t      : per-lane result entry {valid, center}
//   LANES_PER_CHIP: lanes on each ADC chip
// ---------------------------------------------------------------------------
package adc16_sweep_pkg;

    localparam int LANES_PER_CHIP = 8;
    localparam int LANE_W         = 3;
    // Result entries carry the center tap zero-extended to this width, which
    // covers any delay line of up to 256 taps.
    localparam int MAX_TAP_W      = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LANE_RST,
        ST_SETTLE,
        ST_SAMPLE,
        ST_INC,
        ST_CTR_RST,
        ST_CTR_SETTLE,
        ST_CTR_STEP,
        ST_NEXT,
        ST_FINISH
    } sweep_state_t;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAP_W-1:0] center;
    } result_t;

endpackage

// File: rtl/adc16_tap_window_tracker.sv
// ---------------------------------------------------------------------------
// adc16_tap_window_tracker
// Tracks the first contiguous run of good taps seen while a lane is swept
// from tap 0 upward, and reports its center.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clear      : start a new lane (forget the previous window)
//   i_sample_en  : one sample is presented on i_tap / i_good this cycle
//   i_tap        : tap index of the sample
//   i_good       : deskew pattern matched at that tap
//   o_center     : (first+last)>>1, or 0 when no good tap was seen
//   o_valid      : at least one good tap was seen
// ---------------------------------------------------------------------------
module adc16_tap_window_tracker #(
    parameter int TAP_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_sample_en,
    input  logic [TAP_W-1:0] i_tap,
    input  logic             i_good,
    output logic [TAP_W-1:0] o_center,
    output logic             o_valid
);

    logic [TAP_W-1:0] r_first;
    logic [TAP_W-1:0] r_last;
    logic             r_found;
    logic             r_closed;   // first run has ended; later runs are ignored
    logic [TAP_W:0]   w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first  <= '0;
            r_last   <= '0;
            r_found  <= 1'b0;
            r_closed <= 1'b0;
        end else if (i_clear) begin
            r_first  <= '0;
            r_last   <= '0;
            r_found  <= 1'b0;
            r_closed <= 1'b0;
        end else if (i_sample_en) begin
            if (!r_found) begin
                if (i_good) begin
                    r_found <= 1'b1;
                    r_first <= i_tap;
                    r_last  <= i_tap;
                end
            end else if (!r_closed) begin
                if (i_good) begin
                    r_last <= i_tap;
                end else begin
                    r_closed <= 1'b1;
                end
            end
        end
    end

    // One extra bit so first+last cannot wrap before halving.
    assign w_sum    = {1'b0, r_first} + {1'b0, r_last};
    assign o_center = w_sum[TAP_W:1];
    assign o_valid  = r_found;

endmodule

// File: rtl/adc16_tap_sweep_sequencer.sv
// ---------------------------------------------------------------------------
// adc16_tap_sweep_sequencer
// Sweeps the input delay taps of every lane of the selected ADC chips, finds
// the first good eye window per lane, parks the lane at the window center and
// records {valid, center} in a readback array.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : single-cycle sweep request (ignored while busy)
//   chip_mask    : chips to sweep, captured with the accepted start
//   pattern_ok   : per-lane pattern match, index chip*8+lane
//   abort        : (ADC16_TAP_SWEEP_ABORT_EN only) stop the sweep early
//   chip_sel     : one-hot strobe to the external lane encoder
//   lane_sel     : lane addressed by the strobe
//   tap_rst      : strobe qualifier, 1 = reset to tap 0, 0 = increment
//   busy, done   : sweep in progress / one-cycle completion pulse
//   rd_addr      : readback lane index
//   rd_center    : chosen tap for lane rd_addr (combinational)
//   rd_valid     : a good window was found for lane rd_addr
// Build option: define ADC16_TAP_SWEEP_ABORT_EN to add the abort input.
// ---------------------------------------------------------------------------
module adc16_tap_sweep_sequencer
    import adc16_sweep_pkg::*;
#(
    parameter int N_CHIPS       = 8,
    parameter int N_TAPS        = 32,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [N_CHIPS-1:0]              chip_mask,
    input  logic [N_CHIPS*8-1:0]            pattern_ok,
`ifdef ADC16_TAP_SWEEP_ABORT_EN
    input  logic                            abort,
`endif
    output logic [N_CHIPS-1:0]              chip_sel,
    output logic [2:0]                      lane_sel,
    output logic                            tap_rst,
    output logic                            busy,
    output logic                            done,
    input  logic [$clog2(N_CHIPS*8)-1:0]    rd_addr,
    output logic [$clog2(N_TAPS)-1:0]       rd_center,
    output logic                            rd_valid
);

    localparam int TAP_W     = $clog2(N_TAPS);
    localparam int ADDR_W    = $clog2(N_CHIPS * LANES_PER_CHIP);
    localparam int CHIP_W    = (N_CHIPS > 1) ? $clog2(N_CHIPS) : 1;
    localparam int CNT_W     = $clog2(SETTLE_CYCLES + 1);
    localparam int N_ENTRIES = N_CHIPS * LANES_PER_CHIP;

    sweep_state_t         r_state;
    sweep_state_t         w_state_next;

    logic [N_CHIPS-1:0]   r_mask;
    logic [CHIP_W-1:0]    r_chip;
    logic [LANE_W-1:0]    r_lane;
    logic [TAP_W-1:0]     r_tap;
    logic [TAP_W-1:0]     r_step;
    logic [CNT_W-1:0]     r_cnt;
    logic [N_CHIPS-1:0]   r_chip_sel;
    logic                 r_tap_rst;
    logic                 r_busy;
    logic                 r_done;
    result_t              r_results [N_ENTRIES];

    logic                 w_strobe;
    logic                 w_strobe_rst;
    logic                 w_abort;
    logic                 w_abort_hit;
    logic                 w_settle_last;
    logic                 w_lane_last;
    logic [ADDR_W-1:0]    w_lane_idx;
    logic [N_CHIPS-1:0]   w_chip_onehot;
    logic                 w_first_found;
    logic [CHIP_W-1:0]    w_first_chip;
    logic                 w_next_found;
    logic [CHIP_W-1:0]    w_next_chip;
    logic [TAP_W-1:0]     w_center;
    logic                 w_valid;
    logic                 w_wr_en;
    result_t              w_wr_entry;
    result_t              w_rd_entry;

`ifdef ADC16_TAP_SWEEP_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // FINISH is already on its way out, so an abort there changes nothing.
    assign w_abort_hit   = w_abort && (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign w_settle_last = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign w_lane_last   = (r_lane == LANE_W'(LANES_PER_CHIP - 1));
    // chip*8+lane is exactly the concatenation of chip and lane.
    assign w_lane_idx    = ADDR_W'({r_chip, r_lane});

    generate
        for (genvar gi = 0; gi < N_CHIPS; gi++) begin : g_chip_dec
            assign w_chip_onehot[gi] = (r_chip == CHIP_W'(gi));
        end
    endgenerate

    // Lowest selected chip for a new sweep, and the next selected chip above
    // the current one.
    always_comb begin
        w_first_found = 1'b0;
        w_first_chip  = '0;
        w_next_found  = 1'b0;
        w_next_chip   = '0;
        for (int i = 0; i < N_CHIPS; i++) begin
            if (!w_first_found && chip_mask[i]) begin
                w_first_found = 1'b1;
                w_first_chip  = CHIP_W'(i);
            end
            if (!w_next_found && r_mask[i] && (i > int'(r_chip))) begin
                w_next_found = 1'b1;
                w_next_chip  = CHIP_W'(i);
            end
        end
    end

    adc16_tap_window_tracker #(
        .TAP_W (TAP_W)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (r_state == ST_LANE_RST),
        .i_sample_en ((r_state == ST_SAMPLE) && !w_abort_hit),
        .i_tap       (r_tap),
        .i_good      (pattern_ok[w_lane_idx]),
        .o_center    (w_center),
        .o_valid     (w_valid)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and strobe requests
    always_comb begin
        w_state_next = r_state;
        w_strobe     = 1'b0;
        w_strobe_rst = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = w_first_found ? ST_LANE_RST : ST_FINISH;
                end
            end
            ST_LANE_RST: begin
                w_strobe     = 1'b1;
                w_strobe_rst = 1'b1;
                w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_settle_last) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_state_next = (r_tap == TAP_W'(N_TAPS - 1)) ? ST_CTR_RST : ST_INC;
            end
            ST_INC: begin
                w_strobe     = 1'b1;
                w_state_next = ST_SETTLE;
            end
            ST_CTR_RST: begin
                w_strobe     = 1'b1;
                w_strobe_rst = 1'b1;
                w_state_next = ST_CTR_SETTLE;
            end
            ST_CTR_SETTLE: begin
                if (w_settle_last) begin
                    w_state_next = ST_CTR_STEP;
                end
            end
            ST_CTR_STEP: begin
                if (r_step != w_center) begin
                    w_strobe     = 1'b1;
                    w_state_next = ST_CTR_SETTLE;
                end else begin
                    w_state_next = ST_NEXT;
                end
            end
            ST_NEXT: begin
                w_state_next = (!w_lane_last || w_next_found) ? ST_LANE_RST : ST_FINISH;
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_abort_hit) begin
            w_strobe     = 1'b1;
            w_strobe_rst = 1'b1;
            w_state_next = ST_FINISH;
        end
    end

    // Datapath. Strobes are registered one cycle after the requesting state,
    // so lane_sel (updated on entry to LANE_RST) is settled a full cycle
    // before chip_sel rises and is still held the cycle after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask     <= '0;
            r_chip     <= '0;
            r_lane     <= '0;
            r_tap      <= '0;
            r_step     <= '0;
            r_cnt      <= '0;
            r_chip_sel <= '0;
            r_tap_rst  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_chip_sel <= w_strobe ? w_chip_onehot : '0;
            r_tap_rst  <= w_strobe && w_strobe_rst;
            r_done     <= (r_state == ST_FINISH);

            if (((r_state == ST_SETTLE) || (r_state == ST_CTR_SETTLE)) && !w_settle_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end

            // An abort freezes lane/chip so the abort strobe hits the
            // current lane.
            if (!w_abort_hit) begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_mask <= chip_mask;
                            r_chip <= w_first_chip;
                            r_lane <= '0;
                            r_busy <= 1'b1;
                        end
                    end
                    ST_LANE_RST: r_tap  <= '0;
                    ST_INC:      r_tap  <= r_tap + TAP_W'(1);
                    ST_CTR_RST:  r_step <= '0;
                    ST_CTR_STEP: begin
                        if (r_step != w_center) begin
                            r_step <= r_step + TAP_W'(1);
                        end
                    end
                    ST_NEXT: begin
                        if (!w_lane_last) begin
                            r_lane <= r_lane + LANE_W'(1);
                        end else if (w_next_found) begin
                            r_lane <= '0;
                            r_chip <= w_next_chip;
                        end
                    end
                    ST_FINISH:   r_busy <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // Result array. Needs a full clear on reset and combinational readback,
    // so it is built from flops.
    assign w_wr_en           = (r_state == ST_NEXT) && !w_abort_hit;
    assign w_wr_entry.valid  = w_valid;
    assign w_wr_entry.center = MAX_TAP_W'(w_center);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_results[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_results[w_lane_idx] <= w_wr_entry;
        end
    end

    assign w_rd_entry = r_results[rd_addr];
    assign rd_valid   = w_rd_entry.valid;
    assign rd_center  = TAP_W'(w_rd_entry.center);

    assign chip_sel = r_chip_sel;
    assign lane_sel = r_lane;
    assign tap_rst  = r_tap_rst;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_adc16_tap_sweep_sequencer.sv
`timescale 1ns/1ps
module tb_adc16_tap_sweep_sequencer;

    localparam int NC = 2;
    localparam int NT = 32;
    localparam int SC = 2;
    localparam int NL = NC * 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start = 1'b0;
    logic [NC-1:0]   chip_mask = '0;
    logic [NL-1:0]   pattern_ok;
    logic [NC-1:0]   chip_sel;
    logic [2:0]      lane_sel;
    logic            tap_rst;
    logic            busy;
    logic            done;
    logic [3:0]      rd_addr = '0;
    logic [4:0]      rd_center;
    logic            rd_valid;
`ifdef ADC16_TAP_SWEEP_ABORT_EN
    logic            abort = 1'b0;
`endif

    always #5 clk = ~clk;

    adc16_tap_sweep_sequencer #(
        .N_CHIPS       (NC),
        .N_TAPS        (NT),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .chip_mask  (chip_mask),
        .pattern_ok (pattern_ok),
`ifdef ADC16_TAP_SWEEP_ABORT_EN
        .abort      (abort),
`endif
        .chip_sel   (chip_sel),
        .lane_sel   (lane_sel),
        .tap_rst    (tap_rst),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_center  (rd_center),
        .rd_valid   (rd_valid)
    );

    // Delay-line model: each lane's current tap, driven by observed strobes,
    // and a good-window table (two ranges per lane; lo>hi means empty).
    int lo1 [NL];
    int hi1 [NL];
    int lo2 [NL];
    int hi2 [NL];
    int tap_model [NL];

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            pattern_ok[i] = ((tap_model[i] >= lo1[i]) && (tap_model[i] <= hi1[i])) ||
                            ((tap_model[i] >= lo2[i]) && (tap_model[i] <= hi2[i]));
        end
    end

    int cyc = 0;
    int n_strobe = 0;
    int n_rst_strobe = 0;
    int n_chip1_strobe = 0;
    int n_onehot_err = 0;
    int done_cnt = 0;
    int min_gap = 1000000;
    int last_strobe_cyc = -1;
    int last_strobe_lane = -1;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if ($countones(chip_sel) > 1) n_onehot_err = n_onehot_err + 1;
        if (chip_sel != '0) begin
            n_strobe = n_strobe + 1;
            if (tap_rst) n_rst_strobe = n_rst_strobe + 1;
            if (chip_sel[1]) n_chip1_strobe = n_chip1_strobe + 1;
            for (int c = 0; c < NC; c++) begin
                if (chip_sel[c]) begin
                    last_strobe_lane = c * 8 + int'(lane_sel);
                    if (tap_rst) tap_model[c * 8 + int'(lane_sel)] = 0;
                    else         tap_model[c * 8 + int'(lane_sel)] = tap_model[c * 8 + int'(lane_sel)] + 1;
                end
            end
            if (last_strobe_cyc >= 0 && (cyc - last_strobe_cyc) < min_gap) min_gap = cyc - last_strobe_cyc;
            last_strobe_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_entry(input string tag, input int a, input int ev, input int ec);
        rd_addr = 4'(a);
        #1;
        check({tag, "_valid"}, 32'(rd_valid), 32'(ev));
        check({tag, "_center"}, 32'(rd_center), 32'(ec));
    endtask

    task automatic clear_pattern();
        for (int i = 0; i < NL; i++) begin
            lo1[i] = 99; hi1[i] = -1; lo2[i] = 99; hi2[i] = -1;
        end
    endtask

    task automatic do_start(input logic [NC-1:0] m, input int hold);
        @(posedge clk); #1;
        chip_mask = m;
        start = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n = n + 1;
        end
        check({tag, "_done_seen"}, 32'(done === 1'b1), 32'd1);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    int d0;
    int s0;
    int r0;

    initial begin
        for (int i = 0; i < NL; i++) tap_model[i] = 0;
        clear_pattern();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        // Reset state
        check("rst_chip_sel", 32'(chip_sel), 32'd0);
        check("rst_lane_sel", 32'(lane_sel), 32'd0);
        check("rst_tap_rst",  32'(tap_rst),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check_entry("rst_e3", 3, 0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // A: one chip, lane 3 good at 10..20
        $display("step A: mask=01 lane3 window 10..20");
        set_a: begin clear_pattern(); lo1[3] = 10; hi1[3] = 20; end
        d0 = done_cnt;
        do_start(2'b01, 1);
        check("A_busy_started", 32'(busy), 32'd1);
        wait_done("A");
        check("A_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_entry("A_e3", 3, 1, 15);
        check_entry("A_e0", 0, 0, 0);
        check_entry("A_e7", 7, 0, 0);
        check_entry("A_e11", 11, 0, 0);
        check("A_lane3_tap", 32'(tap_model[3]), 32'd15);
        check("A_lane0_tap", 32'(tap_model[0]), 32'd0);
        check("A_chip1_strobes", 32'(n_chip1_strobe), 32'd0);

        // B: window at the top edge, two windows, full-range and single-tap
        $display("step B: lane0 28..31, lane1 2..4+8..12, lane2 0..31, lane4 0..0");
        clear_pattern();
        lo1[0] = 28; hi1[0] = 31;
        lo1[1] = 2;  hi1[1] = 4;  lo2[1] = 8; hi2[1] = 12;
        lo1[2] = 0;  hi1[2] = 31;
        lo1[4] = 0;  hi1[4] = 0;
        d0 = done_cnt;
        do_start(2'b01, 1);
        wait_done("B");
        check("B_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_entry("B_e0", 0, 1, 29);
        check_entry("B_e1", 1, 1, 3);
        check_entry("B_e2", 2, 1, 15);
        check_entry("B_e3", 3, 0, 0);
        check_entry("B_e4", 4, 1, 0);
        check("B_lane0_incs_after_rst", 32'(tap_model[0]), 32'd29);
        check("B_lane1_tap", 32'(tap_model[1]), 32'd3);
        check("B_lane4_tap", 32'(tap_model[4]), 32'd0);

        // C: chip 1 only, start held for five cycles while busy
        $display("step C: mask=10 lane15 window 5..9, start held 5 cycles");
        clear_pattern();
        lo1[15] = 5; hi1[15] = 9;
        d0 = done_cnt;
        s0 = n_chip1_strobe;
        do_start(2'b10, 5);
        wait_done("C");
        repeat (10) @(negedge clk);
        check("C_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("C_busy_idle", 32'(busy), 32'd0);
        check("C_chip1_strobed", 32'(n_chip1_strobe > s0), 32'd1);
        check_entry("C_e15", 15, 1, 7);
        check_entry("C_e8", 8, 0, 0);
        check_entry("C_e0_kept", 0, 1, 29);
        check_entry("C_e1_kept", 1, 1, 3);
        check("C_onehot_err", 32'(n_onehot_err), 32'd0);
        check("C_min_gap_ok", 32'(min_gap >= SC + 1), 32'd1);

        // D: empty mask -> done two cycles after start, no strobes
        $display("step D: mask=00");
        s0 = n_strobe;
        d0 = done_cnt;
        do_start(2'b00, 1);
        check("D_c1_done", 32'(done), 32'd0);
        check("D_c1_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("D_c2_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("D_c3_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("D_strobes", 32'(n_strobe - s0), 32'd0);
        check("D_done_pulses", 32'(done_cnt - d0), 32'd1);

        // E: reset in the first SETTLE cycle, while the lane-reset strobe is up
        $display("step E: reset during SETTLE then clean sweep");
        d0 = done_cnt;
        do_start(2'b01, 1);
        @(posedge clk); #1;
        check("E_strobe_up", 32'(chip_sel), 32'd1);
        check("E_strobe_rst", 32'(tap_rst), 32'd1);
        rst_n = 1'b0;
        #1;
        check("E_chip_sel_0", 32'(chip_sel), 32'd0);
        check("E_tap_rst_0",  32'(tap_rst),  32'd0);
        check("E_busy_0",     32'(busy),     32'd0);
        check("E_done_0",     32'(done),     32'd0);
        check_entry("E_e0_cleared", 0, 0, 0);
        check_entry("E_e15_cleared", 15, 0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("E_no_done", 32'(done_cnt - d0), 32'd0);
        check("E_idle_busy", 32'(busy), 32'd0);
        clear_pattern();
        lo1[3] = 10; hi1[3] = 20;
        do_start(2'b01, 1);
        wait_done("E2");
        check("E2_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_entry("E2_e3", 3, 1, 15);
        check_entry("E2_e0", 0, 0, 0);

`ifdef ADC16_TAP_SWEEP_ABORT_EN
        // F: abort during lane 5
        $display("step F: abort at lane 5");
        clear_pattern();
        lo1[5] = 6; hi1[5] = 8;
        do_start(2'b01, 1);
        wait_done("F1");
        check_entry("F1_e5", 5, 1, 7);
        lo1[5] = 20; hi1[5] = 22;
        d0 = done_cnt;
        do_start(2'b01, 1);
        begin
            int n;
            n = 0;
            while (lane_sel !== 3'd5 && n < 6000) begin
                @(negedge clk);
                n = n + 1;
            end
            check("F_reached_lane5", 32'(lane_sel), 32'd5);
        end
        repeat (20) @(posedge clk);
        #1;
        r0 = n_rst_strobe;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done("F");
        check("F_rst_strobes", 32'(n_rst_strobe - r0), 32'd1);
        check("F_strobe_lane", 32'(last_strobe_lane), 32'd5);
        check("F_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_entry("F_e5_kept", 5, 1, 7);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
